decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL provide parameter SEL_W, default 3, giving the select width; channel count N = 2**SEL_W.
REQ-002 SHALL provide parameter DWELL_W, default 16, giving the dwell-count width.
REQ-003 SHALL provide parameter BLANK_CYC, default 2, giving the all-off cycles inserted between channels; range 1..15.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_en  input  1  1 = drive outputs, 0 = all channels off.
REQ-007 SHALL have port i_mode  input  1  0 = direct select, 1 = auto-scan.
REQ-008 SHALL have port i_sel  input  SEL_W  channel to drive in direct mode.
REQ-009 SHALL have port i_opt  input  1  0 = active-low outputs, 1 = active-high outputs.
REQ-010 SHALL have port i_dwell  input  DWELL_W  cycles per channel in scan mode; 0 treated as 1.
REQ-011 SHALL have port o_y  output  N  registered decoded outputs.
REQ-012 SHALL have port o_sel  output  SEL_W  channel currently driven; holds during blanking.
REQ-013 SHALL have port o_wrap  output  1  one-cycle pulse on each scan wrap.

Function
REQ-014 Selected-channel pattern SHALL be bit k = 0 and all other bits 1 when i_opt=0, inverted bitwise when i_opt=1.
REQ-015 All-off pattern SHALL be all ones when i_opt=0 and all zeros when i_opt=1.
REQ-016 All outputs SHALL be registered, with latency exactly one clock from the inputs to o_y, o_sel and o_wrap.
REQ-017 FSM states SHALL be IDLE (all-off), DRIVE (one channel active) and BLANK (all-off between channels).
REQ-018 With i_en=0 the FSM SHALL enter IDLE on the next edge; o_sel and o_wrap SHALL clear to 0.
REQ-019 IDLE with i_en=1 and i_mode=0 SHALL go to DRIVE on the i_sel value.
REQ-020 IDLE with i_en=1 and i_mode=1 SHALL go to DRIVE on channel 0.
REQ-021 In direct mode, i_sel SHALL be sampled every cycle; a change of i_sel SHALL pass through BLANK before the new channel is driven.
REQ-022 In scan mode, the dwell counter SHALL load max(i_dwell,1) at channel start; a change of i_dwell mid-channel SHALL take effect on the next channel.
REQ-023 At dwell expiry the FSM SHALL go DRIVE -> BLANK -> DRIVE(channel+1 mod N).
REQ-024 On the first DRIVE cycle of channel 0 following channel N-1, o_wrap SHALL be 1 for exactly one cycle.
REQ-025 A 0->1 change of i_mode while enabled SHALL restart the scan at channel 0 with a fresh dwell.
REQ-026 A 1->0 change of i_mode while enabled SHALL drive i_sel, via BLANK only if i_sel differs from o_sel.
REQ-027 A change of i_opt SHALL only re-polarise o_y on the next edge, without disturbing state or counters.
REQ-028 When i_en falls during BLANK or mid-dwell, the sequence SHALL be aborted with no wrap pulse.

Reset
REQ-029 While i_rst=1, o_y SHALL be all ones, o_sel 0, o_wrap 0, FSM IDLE and counters 0, taking effect immediately without a clock.
REQ-030 The first state change after reset release SHALL occur on the first rising edge with i_rst=0.

Configuration
REQ-031 With macro DECODER_SCAN_BLANK_EN defined, BLANK SHALL last BLANK_CYC cycles as specified above.
REQ-032 Without DECODER_SCAN_BLANK_EN, BLANK SHALL be removed, transitions SHALL go DRIVE -> DRIVE directly, and BLANK_CYC SHALL be ignored.

Verification (SEL_W=3, BLANK_CYC=2, blanking enabled unless stated)
REQ-033 Reset asserted mid-scan, between edges -> o_y=8'hFF, o_sel=0, o_wrap=0 immediately.
REQ-034 Direct mode, i_opt=0, i_sel=3 -> o_y=8'b1111_0111 one cycle later; i_opt=1 -> o_y=8'b0000_1000 one cycle later.
REQ-035 Direct mode, i_sel 3->5 -> o_y=8'hFF for 2 cycles, then 8'b1101_1111; o_sel=3 during blank, then 5.
REQ-036 Scan mode, i_dwell=4 -> each channel active 4 cycles plus 2 blank cycles; full frame 48 cycles; o_wrap single pulse with o_sel=0.
REQ-037 Scan mode, i_dwell=0 -> 1-cycle dwell per channel; macro undefined -> no blank cycles, channel advances every cycle, o_wrap every 8 cycles.
REQ-038 i_en dropped mid-dwell on channel 7 -> IDLE next edge, o_y all-off, no o_wrap; i_en restored -> scan restarts at channel 0.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-way channel decoder with direct-select and auto-scan modes.
// Build macro DECODER_SCAN_BLANK_EN inserts BLANK_CYC all-off cycles between channels.
module decoder_scan #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned DWELL_W   = 16,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_mode,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_opt,
    input  logic [DWELL_W-1:0]      i_dwell,
    output logic [(1<<SEL_W)-1:0]   o_y,
    output logic [SEL_W-1:0]        o_sel,
    output logic                    o_wrap
);
    localparam int unsigned N = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_e;

    if (BLANK_CYC < 1 || BLANK_CYC > 15) begin : g_blank_cyc_range
        $error("decoder_scan: BLANK_CYC must be in 1..15");
    end

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 wrap_q, wrap_d;
    logic                 mode_q, mode_d;
    logic [N-1:0]         y_q, y_d;
    logic [DWELL_W-1:0]   dwell_eff_c;
    logic [N-1:0]         onehot_c;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int unsigned BCNT_W     = 4;
    localparam logic [BCNT_W-1:0] BLANK_LOAD = BCNT_W'(BLANK_CYC - 1);

    logic [BCNT_W-1:0]    blank_q, blank_d;
    logic [SEL_W-1:0]     nxt_q, nxt_d;
`endif

    assign dwell_eff_c = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= 1'b0;
            y_q     <= '1;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= '0;
            nxt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= blank_d;
            nxt_q   <= nxt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        mode_d  = i_mode;
`ifdef DECODER_SCAN_BLANK_EN
        blank_d = blank_q;
        nxt_d   = nxt_q;
`endif
        if (!i_en) begin
            state_d = IDLE;
            sel_d   = '0;
            dwell_d = '0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_d = '0;
            nxt_d   = '0;
`endif
        end else if (i_mode && (!mode_q || state_q == IDLE)) begin
            // Scan entry or 0->1 mode change: restart at channel 0 with a fresh dwell
            state_d = DRIVE;
            sel_d   = '0;
            dwell_d = dwell_eff_c;
`ifdef DECODER_SCAN_BLANK_EN
            blank_d = '0;
`endif
        end else if (state_q == IDLE) begin
            state_d = DRIVE;
            sel_d   = i_sel;
        end else if (state_q == DRIVE) begin
            if (!i_mode) begin
                if (i_sel != sel_q) begin
`ifdef DECODER_SCAN_BLANK_EN
                    state_d = BLANK;
                    blank_d = BLANK_LOAD;
`else
                    sel_d   = i_sel;
`endif
                end
            end else if (dwell_q <= DWELL_W'(1)) begin
`ifdef DECODER_SCAN_BLANK_EN
                state_d = BLANK;
                blank_d = BLANK_LOAD;
                nxt_d   = sel_q + SEL_W'(1);
`else
                sel_d   = sel_q + SEL_W'(1);
                dwell_d = dwell_eff_c;
                wrap_d  = (sel_q == SEL_W'(N - 1));
`endif
            end else begin
                dwell_d = dwell_q - DWELL_W'(1);
            end
        end
`ifdef DECODER_SCAN_BLANK_EN
        else begin
            // o_sel holds the previous channel until blanking completes
            if (blank_q != '0) begin
                blank_d = blank_q - BCNT_W'(1);
            end else begin
                state_d = DRIVE;
                if (i_mode) begin
                    sel_d   = nxt_q;
                    dwell_d = dwell_eff_c;
                    wrap_d  = (nxt_q == '0);
                end else begin
                    sel_d   = i_sel;
                end
            end
        end
`endif
    end

    // Output pattern for the upcoming cycle, polarised by i_opt
    always_comb begin
        onehot_c = N'(1) << sel_d;
        if (state_d == DRIVE) begin
            y_d = i_opt ? onehot_c : ~onehot_c;
        end else begin
            y_d = i_opt ? '0 : '1;
        end
    end

    assign o_y    = y_q;
    assign o_sel  = sel_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed vector table plus hand-written scan/blank/reset sequences
// for decoder_scan at SEL_W=3, DWELL_W=16, BLANK_CYC=2.
module tb_decoder_scan;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int BLANK_EFF = 2;
`else
    localparam int BLANK_EFF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic        opt;
    logic [15:0] dwell;
    logic [7:0]  o_y;
    logic [2:0]  o_sel;
    logic        o_wrap;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic        mode;
        logic [2:0]  sel;
        logic        opt;
        logic [15:0] dwell;
        logic [7:0]  y;
        logic [2:0]  esel;
        logic        wrap;
    } vec_t;

    vec_t tbl[16];

    decoder_scan #(.SEL_W(3), .DWELL_W(16), .BLANK_CYC(2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_mode  (mode),
        .i_sel   (sel),
        .i_opt   (opt),
        .i_dwell (dwell),
        .o_y     (o_y),
        .o_sel   (o_sel),
        .o_wrap  (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ey, input logic [2:0] es,
                         input logic ew);
        n_vec++;
        if (o_y !== ey || o_sel !== es || o_wrap !== ew) begin
            n_err++;
            $display("FAIL %s: got y=%h sel=%0d wrap=%b, expected y=%h sel=%0d wrap=%b",
                     name, o_y, o_sel, o_wrap, ey, es, ew);
        end
    endtask

    function automatic logic [7:0] on_pat(input int ch, input logic p);
        logic [7:0] v;
        v = 8'(1) << ch;
        return p ? v : ~v;
    endfunction

    task automatic scan_channel(input int ch, input int ncyc, input logic first_wrap);
        for (int k = 0; k < ncyc; k++) begin
            step();
            check("scan_drive", on_pat(ch, 1'b0), 3'(ch), first_wrap && (k == 0));
        end
        for (int b = 0; b < BLANK_EFF; b++) begin
            step();
            check("scan_blank", 8'hFF, 3'(ch), 1'b0);
        end
    endtask

    initial begin
        //            en    mode  sel   opt   dwell   y      esel  wrap
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 16'd0, 8'hFF, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 16'd0, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd3, 1'b0, 16'd0, 8'hF7, 3'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd3, 1'b1, 16'd0, 8'h08, 3'd3, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd3, 1'b0, 16'd0, 8'hF7, 3'd3, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd3, 1'b0, 16'd0, 8'hFF, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd6, 1'b1, 16'd0, 8'h40, 3'd6, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 3'd6, 1'b1, 16'd0, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd5, 1'b0, 16'd3, 8'hFE, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd5, 1'b0, 16'd3, 8'hFE, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd5, 1'b0, 16'd3, 8'hFF, 3'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'd3, 8'hFE, 3'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd0, 1'b0, 16'd1, 8'hFE, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 3'd0, 1'b0, 16'd1, 8'hFF, 3'd0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd0, 1'b0, 16'd5, 8'hFE, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'd5, 8'hFE, 3'd0, 1'b0};

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0; opt = 1'b1; dwell = 16'd0;
        #1;
        check("reset_async_start", 8'hFF, 3'd0, 1'b0);
        step();
        check("reset_held", 8'hFF, 3'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
            opt = tbl[i].opt; dwell = tbl[i].dwell;
            step();
            check($sformatf("vec%0d", i), tbl[i].y, tbl[i].esel, tbl[i].wrap);
        end

        // Direct mode channel change 3 -> 5 passes through blanking
        en = 1'b0; step();
        check("dir_idle", 8'hFF, 3'd0, 1'b0);
        en = 1'b1; mode = 1'b0; sel = 3'd3; opt = 1'b0; step();
        check("dir_sel3", 8'hF7, 3'd3, 1'b0);
        sel = 3'd5;
        for (int b = 0; b < BLANK_EFF; b++) begin
            step();
            check("dir_blank", 8'hFF, 3'd3, 1'b0);
        end
        step();
        check("dir_sel5", 8'hDF, 3'd5, 1'b0);
        step();
        check("dir_sel5_hold", 8'hDF, 3'd5, 1'b0);

        // Scan dwell=4: two full frames, wrap at frame start, then a mid-channel dwell change
        en = 1'b0; step();
        check("scan4_idle", 8'hFF, 3'd0, 1'b0);
        en = 1'b1; mode = 1'b1; dwell = 16'd4;
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 8; ch++)
                scan_channel(ch, 4, (f > 0) && (ch == 0));
        step();
        check("scan4_wrap", 8'hFE, 3'd0, 1'b1);
        dwell = 16'd2;
        for (int k = 1; k < 4; k++) begin
            step();
            check("scan4_old_dwell", 8'hFE, 3'd0, 1'b0);
        end
        for (int b = 0; b < BLANK_EFF; b++) begin
            step();
            check("scan4_blank", 8'hFF, 3'd0, 1'b0);
        end
        scan_channel(1, 2, 1'b0);
        scan_channel(2, 2, 1'b0);

        // Scan dwell=0 behaves as dwell=1
        en = 1'b0; step();
        check("scan0_idle", 8'hFF, 3'd0, 1'b0);
        en = 1'b1; dwell = 16'd0;
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 8; ch++)
                scan_channel(ch, 1, (f > 0) && (ch == 0));
        step();
        check("scan0_wrap", 8'hFE, 3'd0, 1'b1);

        // Enable dropped mid-dwell on channel 7: abort without wrap, restart at channel 0
        en = 1'b0; step();
        check("abort_idle0", 8'hFF, 3'd0, 1'b0);
        en = 1'b1; dwell = 16'd3;
        for (int ch = 0; ch < 7; ch++) scan_channel(ch, 3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("abort_ch7", 8'h7F, 3'd7, 1'b0);
        end
        en = 1'b0; step();
        check("abort_off", 8'hFF, 3'd0, 1'b0);
        step();
        check("abort_off_hold", 8'hFF, 3'd0, 1'b0);
        en = 1'b1; step();
        check("abort_restart", 8'hFE, 3'd0, 1'b0);
        step();
        check("abort_restart2", 8'hFE, 3'd0, 1'b0);

        // Polarity flip mid-dwell leaves the dwell counter untouched
        opt = 1'b1; step();
        check("opt_flip", 8'h01, 3'd0, 1'b0);
        step();
        check("opt_dwell_kept", (BLANK_EFF > 0) ? 8'h00 : 8'h02,
              (BLANK_EFF > 0) ? 3'd0 : 3'd1, 1'b0);

        // Asynchronous reset between edges, then release
        #2 rst = 1'b1;
        #1;
        check("rst_async_mid", 8'hFF, 3'd0, 1'b0);
        step();
        check("rst_hold_edge", 8'hFF, 3'd0, 1'b0);
        rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd2; opt = 1'b1;
        step();
        check("rst_release", 8'h04, 3'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
